// File: rtl/gcd_datapath.sv
`default_nettype none
// ============================================================================
// Module      : gcd_datapath
// Description : GCD datapath. X/Y operand registers, one shared subtractor,
//               a comparator feeding the controller, a result register with
//               a valid/ready handshake, an iteration counter and diagnostic
//               flags.
// Revision    : 1.0  initial release
// ============================================================================
module gcd_datapath #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic              xsel,
  input  logic              xload,
  input  logic              ysel,
  input  logic              yload,
  input  logic              sub_sel,
  input  logic              done,
  output logic              x_eq_y,
  output logic              x_gt_y,
  output logic [WIDTH-1:0]  result,
  output logic [ITER_W-1:0] result_iters,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic              iter_sat,
  output logic              err_zero,
  output logic              overrun
);

  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [ITER_W-1:0] res_it_q, res_it_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic [WIDTH-1:0]  diff;
  logic              x_load_a;
  logic              y_load_b;
  logic              diff_load;
  logic              xfer;

  // Shared subtractor; order chosen by the controller, wraps modulo 2^WIDTH.
  always_comb begin
    diff = sub_sel ? (y_q - x_q) : (x_q - y_q);
  end

  assign x_load_a  = xload & xsel;
  assign y_load_b  = yload & ysel;
  assign diff_load = (xload & ~xsel) | (yload & ~ysel);
  assign xfer      = valid_q & result_ready;

  // Comparator straight off the registers: zero-cycle status to the controller.
  assign x_eq_y = (x_q == y_q);
  assign x_gt_y = (x_q > y_q);

  assign iter_sat     = &iter_q;
  assign iter_count   = iter_q;
  assign err_zero     = err_q;
  assign result       = res_q;
  assign result_iters = res_it_q;
  assign result_valid = valid_q;
  assign overrun      = ovr_q;

  // Next-state logic for operands, counter, flags and result handshake.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    iter_d   = iter_q;
    err_d    = err_q;
    res_d    = res_q;
    res_it_d = res_it_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    // Both registers see the same pre-edge diff when loaded together.
    if (xload) x_d = xsel ? a_in : diff;
    if (yload) y_d = ysel ? b_in : diff;

    // A fresh A load starts a new run; one increment per cycle at most.
    if (x_load_a) begin
      iter_d = '0;
    end else if (diff_load && !iter_sat) begin
      iter_d = iter_q + 1'b1;
    end

    // Zero operand means the subtract loop can never converge.
    if (x_load_a) begin
      err_d = 1'b0;
    end else if (y_load_b && ((b_in == '0) || (x_q == '0))) begin
      err_d = 1'b1;
    end

    // New result wins over a transfer; overwriting unconsumed data is flagged.
    if (done) begin
      res_d    = x_q;
      res_it_d = iter_q;
      valid_d  = 1'b1;
      if (valid_q && !result_ready) ovr_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q      <= '0;
      y_q      <= '0;
      iter_q   <= '0;
      err_q    <= 1'b0;
      res_q    <= '0;
      res_it_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      iter_q   <= iter_d;
      err_q    <= err_d;
      res_q    <= res_d;
      res_it_q <= res_it_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_datapath
// Description : Self-checking bench for gcd_datapath. Two instances share
//               the stimulus: default widths and ITER_W=4 for saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gcd_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_in, b_in;
  logic       xsel, xload, ysel, yload, sub_sel, done, result_ready;

  logic       eq, gt, rv, isat, ez, ovr;
  logic [7:0] res, rit, ic;
  logic       eq4, gt4, rv4, isat4, ez4, ovr4;
  logic [7:0] res4;
  logic [3:0] rit4, ic4;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state (iteration counts kept unbounded, saturated on compare)
  logic [7:0] mx, my, mres;
  int         mit, mres_it;
  bit         merr, mval, mover;

  always #5 clk = ~clk;

  gcd_datapath #(.WIDTH(8), .ITER_W(8)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .xsel(xsel), .xload(xload), .ysel(ysel), .yload(yload),
    .sub_sel(sub_sel), .done(done), .x_eq_y(eq), .x_gt_y(gt),
    .result(res), .result_iters(rit), .result_valid(rv),
    .result_ready(result_ready), .iter_count(ic), .iter_sat(isat),
    .err_zero(ez), .overrun(ovr)
  );

  gcd_datapath #(.WIDTH(8), .ITER_W(4)) dut4 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .xsel(xsel), .xload(xload), .ysel(ysel), .yload(yload),
    .sub_sel(sub_sel), .done(done), .x_eq_y(eq4), .x_gt_y(gt4),
    .result(res4), .result_iters(rit4), .result_valid(rv4),
    .result_ready(result_ready), .iter_count(ic4), .iter_sat(isat4),
    .err_zero(ez4), .overrun(ovr4)
  );

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Drive one cycle of strobes, advance the model by the stated rules,
  // and return #1 after the clock edge.
  task automatic cyc(input bit xs, xl, ys, yl, ss, dn, rdy,
                     input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d, nx, ny;
    int         nit;
    bit         nerr;
    xsel = xs; xload = xl; ysel = ys; yload = yl;
    sub_sel = ss; done = dn; result_ready = rdy; a_in = a; b_in = b;
    d    = ss ? 8'(my - mx) : 8'(mx - my);
    nx   = xl ? (xs ? a : d) : mx;
    ny   = yl ? (ys ? b : d) : my;
    nit  = mit;
    if (xl && xs) nit = 0;
    else if ((xl && !xs) || (yl && !ys)) nit = sat(mit + 1, 100000);
    nerr = merr;
    if (xl && xs) nerr = 0;
    else if (yl && ys && (b == 0 || mx == 0)) nerr = 1;
    if (dn) begin
      if (mval && !rdy) mover = 1;
      mres = mx; mres_it = mit; mval = 1;
    end else if (mval && rdy) begin
      mval = 0;
    end
    mx = nx; my = ny; mit = nit; merr = nerr;
    @(posedge clk); #1;
    xload = 0; yload = 0; done = 0; result_ready = 0;
  endtask

  task automatic ld_a(input logic [7:0] a);  cyc(1,1,0,0,0,0,0,a,8'd0); endtask
  task automatic ld_b(input logic [7:0] b);  cyc(0,0,1,1,0,0,0,8'd0,b); endtask
  task automatic x_step();                   cyc(0,1,0,0,0,0,0,8'd0,8'd0); endtask
  task automatic y_step();                   cyc(0,0,0,1,1,0,0,8'd0,8'd0); endtask
  task automatic fin(input bit rdy);         cyc(0,0,0,0,0,1,rdy,8'd0,8'd0); endtask

  task automatic do_reset();
    rst = 0; xsel = 1; xload = 1; ysel = 0; yload = 1; sub_sel = 0;
    done = 1; result_ready = 1; a_in = 8'd99; b_in = 8'd77;
    @(posedge clk); #1;
    rst = 1; xload = 0; yload = 0; done = 0; result_ready = 0;
    mx = 0; my = 0; mres = 0; mit = 0; mres_it = 0; merr = 0; mval = 0; mover = 0;
  endtask

  task automatic test_reset();
    logic [29:0] got, exp;
    do_reset();
    got = {eq, gt, res, rit, rv, ic, isat, ez, ovr};
    exp = {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_outputs actual=%h required=%h", got, exp);
    end
    n_cmp++;
    if ({dut.x_q, dut.y_q} !== 16'd0) begin
      n_err++; $display("FAIL reset_xy actual=%h required=0", {dut.x_q, dut.y_q});
    end
  endtask

  task automatic test_gcd_48_18();
    do_reset();
    ld_a(8'd48); ld_b(8'd18);
    n_cmp++;
    if ({eq, gt} !== 2'b01) begin n_err++; $display("FAIL g48_cmp0 actual=%b required=01", {eq, gt}); end
    x_step();
    n_cmp++;
    if (dut.x_q !== 8'd30) begin n_err++; $display("FAIL g48_x30 actual=%0d required=30", dut.x_q); end
    x_step();
    n_cmp++;
    if (dut.x_q !== 8'd12 || gt !== 1'b0) begin
      n_err++; $display("FAIL g48_x12 actual=%0d/gt%b required=12/gt0", dut.x_q, gt);
    end
    y_step();
    n_cmp++;
    if (dut.y_q !== 8'd6 || gt !== 1'b1) begin
      n_err++; $display("FAIL g48_y6 actual=%0d/gt%b required=6/gt1", dut.y_q, gt);
    end
    x_step();
    n_cmp++;
    if (dut.x_q !== 8'd6 || eq !== 1'b1) begin
      n_err++; $display("FAIL g48_x6 actual=%0d/eq%b required=6/eq1", dut.x_q, eq);
    end
    fin(0);
    n_cmp++;
    if ({res, rit, rv} !== {8'd6, 8'd4, 1'b1}) begin
      n_err++; $display("FAIL g48_result actual=%0d/%0d/%b required=6/4/1", res, rit, rv);
    end
  endtask

  task automatic test_equal();
    do_reset();
    ld_a(8'd7); ld_b(8'd7);
    n_cmp++;
    if ({eq, gt} !== 2'b10) begin n_err++; $display("FAIL eq7_cmp actual=%b required=10", {eq, gt}); end
    fin(0);
    n_cmp++;
    if ({res, rit, rv} !== {8'd7, 8'd0, 1'b1}) begin
      n_err++; $display("FAIL eq7_result actual=%0d/%0d/%b required=7/0/1", res, rit, rv);
    end
    cyc(0,0,0,0,0,0,1,8'd0,8'd0);
    n_cmp++;
    if (rv !== 1'b0 || res !== 8'd7) begin
      n_err++; $display("FAIL eq7_accept actual=v%b/%0d required=v0/7", rv, res);
    end
  endtask

  task automatic test_err_zero();
    do_reset();
    ld_a(8'd0); ld_b(8'd5);
    n_cmp++;
    if (ez !== 1'b1) begin n_err++; $display("FAIL ez_a0 actual=%b required=1", ez); end
    ld_a(8'd9);
    n_cmp++;
    if (ez !== 1'b0) begin n_err++; $display("FAIL ez_clear actual=%b required=0", ez); end
    ld_b(8'd3);
    n_cmp++;
    if (ez !== 1'b0) begin n_err++; $display("FAIL ez_nonzero actual=%b required=0", ez); end
    ld_b(8'd0);
    n_cmp++;
    if (ez !== 1'b1) begin n_err++; $display("FAIL ez_b0 actual=%b required=1", ez); end
  endtask

  task automatic test_overrun();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ld_a(8'd12); ld_b(8'd8); x_step(); y_step(); fin(0);
      n_cmp++;
      if ({res, rv, ovr} !== {8'd4, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL ovr_first actual=%0d/v%b/o%b required=4/v1/o0", res, rv, ovr);
      end
      ld_a(8'd9); ld_b(8'd6); x_step(); y_step();
      fin(pass == 1);
      n_cmp++;
      if ({res, rv, ovr} !== {8'd3, 1'b1, (pass == 0) ? 1'b1 : 1'b0}) begin
        n_err++; $display("FAIL ovr_second pass%0d actual=%0d/v%b/o%b required=3/v1/o%0d",
                          pass, res, rv, ovr, (pass == 0));
      end
    end
    // Sticky across a later accept
    cyc(0,0,0,0,0,0,1,8'd0,8'd0);
    fin(0); fin(0);
    n_cmp++;
    if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_sticky actual=%b required=1", ovr); end
  endtask

  task automatic test_saturation();
    do_reset();
    ld_a(8'd20); ld_b(8'd1);
    for (int i = 1; i <= 19; i++) begin
      x_step();
      if (i == 14) begin
        n_cmp++;
        if ({ic4, isat4} !== {4'd14, 1'b0}) begin
          n_err++; $display("FAIL sat_14 actual=%0d/%b required=14/0", ic4, isat4);
        end
      end
    end
    n_cmp++;
    if ({ic4, isat4, dut4.x_q} !== {4'd15, 1'b1, 8'd1}) begin
      n_err++; $display("FAIL sat_end actual=%0d/%b/x%0d required=15/1/x1", ic4, isat4, dut4.x_q);
    end
    n_cmp++;
    if ({ic, isat} !== {8'd19, 1'b0}) begin
      n_err++; $display("FAIL sat_wide actual=%0d/%b required=19/0", ic, isat);
    end
    fin(0);
    n_cmp++;
    if ({res4, rit4} !== {8'd1, 4'd15}) begin
      n_err++; $display("FAIL sat_result actual=%0d/%0d required=1/15", res4, rit4);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] got, exp;
    do_reset();
    ld_a(8'd48); fin(0); ld_b(8'd0); ld_b(8'd18); x_step(); x_step();
    do_reset();
    got = {eq, gt, res, rit, rv, ic, isat, ez, ovr};
    exp = {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp || {dut.x_q, dut.y_q} !== 16'd0) begin
      n_err++; $display("FAIL reset_mid actual=%h/%h required=%h/0", got, {dut.x_q, dut.y_q}, exp);
    end
  endtask

  task automatic test_random_strobes();
    logic [29:0] got, exp;
    logic [26:0] got4, exp4;
    bit xs, xl, ys, yl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      xs = ($urandom_range(0, 3) == 0);
      xl = ($urandom_range(0, 2) != 0);
      ys = ($urandom_range(0, 3) == 0);
      yl = ($urandom_range(0, 2) != 0);
      cyc(xs, xl, ys, yl, 1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
          ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
          ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
      exp  = {mx == my, mx > my, mres, 8'(sat(mres_it, 255)), mval, 8'(sat(mit, 255)),
              mit >= 255, merr, mover};
      got  = {eq, gt, res, rit, rv, ic, isat, ez, ovr};
      exp4 = {mx == my, mx > my, mres, 4'(sat(mres_it, 15)), mval, 4'(sat(mit, 15)),
              mit >= 15, merr, mover};
      got4 = {eq4, gt4, res4, rit4, rv4, ic4, isat4, ez4, ovr4};
      n_cmp++;
      if (got !== exp || got4 !== exp4) begin
        n_err++; $display("FAIL rand_cycle%0d actual=%h/%h required=%h/%h", i, got, got4, exp, exp4);
      end
    end
  endtask

  task automatic test_random_gcd();
    int a, b, steps;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      a = $urandom_range(1, 255);
      b = $urandom_range(1, 255);
      ld_a(8'(a)); ld_b(8'(b));
      steps = 0;
      while (eq !== 1'b1 && steps < 600) begin
        if (gt === 1'b1) x_step(); else y_step();
        steps++;
      end
      fin(1'($urandom));
      n_cmp++;
      if (res !== 8'(gcd_ref(a, b)) || rit !== 8'(sat(steps, 255)) || rv !== 1'b1) begin
        n_err++; $display("FAIL rand_gcd(%0d,%0d) actual=%0d/%0d/v%b required=%0d/%0d/v1",
                          a, b, res, rit, rv, gcd_ref(a, b), sat(steps, 255));
      end
      n_cmp++;
      if (ovr !== mover) begin
        n_err++; $display("FAIL rand_gcd_ovr actual=%b required=%b", ovr, mover);
      end
    end
  endtask

  initial begin
    rst = 0; a_in = 0; b_in = 0; xsel = 0; xload = 0; ysel = 0; yload = 0;
    sub_sel = 0; done = 0; result_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_gcd_48_18();
    test_equal();
    test_err_zero();
    test_overrun();
    test_saturation();
    test_reset_mid();
    test_random_strobes();
    test_random_gcd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
